tdc_readout: RTL and testbench

TDC_READOUT -- requirements
Module: tdc_readout

---
 rtl/tdc_readout.sv | 160 ++++++++++++++++
 tb/tb_tdc_readout.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_readout.sv
// Delay-line TDC readout: launches 2^LOG2_SAMPLES measurements, decodes the thermometer
// word, accumulates and averages. Define TDC_BUBBLE_FIX_EN to add a 3-tap majority bubble filter.
module tdc_readout #(
    parameter int N_DELAY      = 32,
    parameter int LOG2_SAMPLES = 4,
    parameter int SETTLE_CYC   = 2,
    localparam int CW          = $clog2(N_DELAY + 1),
    localparam int SW          = CW + LOG2_SAMPLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    output logic               start,
    input  logic [N_DELAY-1:0] time_count,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CW-1:0]      res_avg,
    output logic [SW-1:0]      res_sum,
    output logic               res_sat
);

    localparam int SMP_W = LOG2_SAMPLES + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic [3:0]       SET_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      acc_q, acc_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [3:0]         set_q, set_d;
    logic               sat_q, sat_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               vld_q, vld_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [CW-1:0]      avg_q, avg_d;
    logic               rsat_q, rsat_d;
    logic [N_DELAY-1:0] tap_word;
    logic [CW-1:0]      tap_cnt;

    // Leading run of ones from the earliest tap; anything past the first zero is ignored.
    function automatic logic [CW-1:0] therm_count(input logic [N_DELAY-1:0] w);
        logic [CW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < N_DELAY; i++) begin
            if (run && w[i]) n = n + CW'(1);
            else             run = 1'b0;
        end
        return n;
    endfunction

`ifdef TDC_BUBBLE_FIX_EN
    // Edges behave as a virtual 1 below tap 0 and a virtual 0 above the last tap.
    function automatic logic [N_DELAY-1:0] bubble_fix(input logic [N_DELAY-1:0] w);
        logic [N_DELAY+1:0] e;
        logic [N_DELAY-1:0] f;
        e = {1'b0, w, 1'b1};
        for (int i = 0; i < N_DELAY; i++)
            f[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
        return f;
    endfunction

    assign tap_word = bubble_fix(time_count);
`else
    assign tap_word = time_count;
`endif

    assign tap_cnt = therm_count(tap_word);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        smp_d   = smp_q;
        set_d   = set_q;
        sat_d   = sat_q;
        vld_d   = vld_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        rsat_d  = rsat_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = LAUNCH;
                    acc_d   = '0;
                    smp_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = SETTLE;
                set_d   = '0;
            end
            SETTLE: begin
                if (set_q == SET_LAST) state_d = SAMPLE;
                else                   set_d   = set_q + 4'd1;
            end
            SAMPLE: begin
                acc_d = acc_q + SW'(tap_cnt);
                smp_d = smp_q + SMP_W'(1);
                if (tap_cnt == CW'(N_DELAY)) sat_d = 1'b1;
                state_d = (smp_q == SMP_LAST) ? DONE : LAUNCH;
            end
            DONE: begin
                // First DONE cycle publishes the result; later cycles wait for the handshake.
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    sum_d  = acc_q;
                    avg_d  = CW'(acc_q >> LOG2_SAMPLES);
                    rsat_d = sat_q;
                end else if (res_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == LAUNCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            smp_q   <= '0;
            set_q   <= '0;
            sat_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            avg_q   <= '0;
            rsat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            smp_q   <= smp_d;
            set_q   <= set_d;
            sat_q   <= sat_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            rsat_q  <= rsat_d;
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign res_valid = vld_q;
    assign res_sum   = sum_q;
    assign res_avg   = avg_q;
    assign res_sat   = rsat_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Scoreboard bench for tdc_readout (default parameters); expectations come from a
// reference decode of the per-sample pattern table, plus fixed known-answer values.
module tb_tdc_readout;

    localparam int NS  = 16;
    localparam int LAT = 1 + NS * (2 + 2);

    logic        clk = 1'b0;
    logic        rst, trig, start, busy, res_valid, res_ready, res_sat;
    logic [31:0] time_count;
    logic [5:0]  res_avg;
    logic [9:0]  res_sum;

    typedef struct {
        int sum;
        int avg;
        int sat;
        int acc_cyc;
        int base;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tc_pat [NS];
    logic [3:0]  sidx;
    int          cyc = 0, start_cnt = 0, base = 0;
    int          n_checks = 0, n_errors = 0;

    tdc_readout dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .start      (start),
        .time_count (time_count),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_avg    (res_avg),
        .res_sum    (res_sum),
        .res_sat    (res_sat)
    );

    always #5 clk = ~clk;

    // Sample k of a measurement sees pattern k (index advances on each start pulse).
    assign sidx       = 4'(start_cnt - base - 1);
    assign time_count = tc_pat[sidx];

    function automatic int model_count(input logic [31:0] w_in);
        logic [31:0] w;
        int          n;
        w = w_in;
`ifdef TDC_BUBBLE_FIX_EN
        begin
            logic [33:0] e;
            e = {1'b0, w_in, 1'b1};
            for (int i = 0; i < 32; i++)
                w[i] = ((int'(e[i]) + int'(e[i+1]) + int'(e[i+2])) >= 2);
        end
`endif
        n = 0;
        while (n < 32 && w[n]) n++;
        return n;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        int   c;
        e.sum = 0;
        e.sat = 0;
        for (int i = 0; i < NS; i++) begin
            c = model_count(tc_pat[i]);
            e.sum += c;
            if (c == 32) e.sat = 1;
        end
        e.avg     = e.sum / NS;
        e.acc_cyc = 0;
        e.base    = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cnt <= start_cnt + 1;
        if (rst) begin
            sb_q.delete();
        end else if (trig && !busy) begin
            exp_t e;
            e         = model_exp();
            e.acc_cyc = cyc + 1;
            e.base    = start_cnt;
            base     <= start_cnt;
            sb_q.push_back(e);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output exp_t r, output bit ok);
        int n;
        ok = 1'b0;
        r  = '{default: 0};
        n  = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            check_val("result_timeout", 0, 1);
        end else if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
        end else begin
            r  = sb_q.pop_front();
            ok = 1'b1;
            check_val("res_sum", 32'(res_sum), r.sum);
            check_val("res_avg", 32'(res_avg), r.avg);
            check_val("res_sat", 32'(res_sat), r.sat);
            check_val("latency", cyc - r.acc_cyc, LAT);
            check_val("start_pulses", start_cnt - r.base, NS);
        end
    endtask

    task automatic accept(input exp_t r, input int hold, input bit keep);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            trig      = i[0];
            tick();
            check_val("hold_valid", 32'(res_valid), 1);
            check_val("hold_sum", 32'(res_sum), r.sum);
            check_val("hold_avg", 32'(res_avg), r.avg);
            check_val("hold_sat", 32'(res_sat), r.sat);
            check_val("hold_no_start", 32'(start), 0);
        end
        trig      = 1'b1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        trig      = keep;
        check_val("post_hs_valid", 32'(res_valid), 0);
        check_val("post_hs_busy", 32'(busy), 0);
    endtask

    task automatic meas(input int es, input int ea, input int esat, input int hold);
        exp_t r;
        bit   ok;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check_val("busy_after_trig", 32'(busy), 1);
        wait_result(r, ok);
        if (ok) begin
            if (es >= 0) begin
                check_val("kat_sum", 32'(res_sum), es);
                check_val("kat_avg", 32'(res_avg), ea);
                check_val("kat_sat", 32'(res_sat), esat);
            end
            accept(r, hold, 1'b0);
        end
    endtask

    initial begin
        exp_t r;
        bit   ok;
        int   n, seen, k;

        rst       = 1'b1;
        trig      = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < NS; i++) tc_pat[i] = 32'h0000_00FF;
        repeat (3) tick();
        check_val("rst_start", 32'(start), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_valid", 32'(res_valid), 0);
        check_val("rst_avg", 32'(res_avg), 0);
        check_val("rst_sum", 32'(res_sum), 0);
        check_val("rst_sat", 32'(res_sat), 0);
        rst  = 1'b0;
        trig = 1'b0;
        tick();
        check_val("trig_with_rst_ignored", 32'(busy), 0);

        meas(128, 8, 0, 10);

        for (int i = 0; i < NS; i++) tc_pat[i] = 32'h0000_007B;
`ifdef TDC_BUBBLE_FIX_EN
        meas(112, 7, 0, 1);
`else
        meas(32, 2, 0, 1);
`endif

        for (int i = 0; i < NS; i++) tc_pat[i] = i[0] ? 32'h0000_001F : 32'h0000_000F;
        meas(72, 4, 0, 2);

        tc_pat[5] = 32'hFFFF_FFFF;
        meas(99, 6, 1, 0);

        for (int i = 0; i < NS; i++) tc_pat[i] = 32'h0000_0000;
        meas(0, 0, 0, 0);

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < NS; i++) begin
                k         = $urandom_range(0, 32);
                tc_pat[i] = (k == 32) ? 32'hFFFF_FFFF : ((32'h1 << k) - 32'h1);
                if ($urandom_range(0, 1) == 1) tc_pat[i][$urandom_range(0, 31)] ^= 1'b1;
            end
            meas(-1, 0, 0, 1);
        end

        // Abort during the fifth settle window.
        for (int i = 0; i < NS; i++) tc_pat[i] = 32'h0000_00FF;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n    = 0;
        seen = 0;
        while (seen < 5 && n < 100) begin
            tick();
            n++;
            if (start) seen++;
        end
        check_val("abort_reach_5th_start", seen, 5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_start", 32'(start), 0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_valid", 32'(res_valid), 0);
        check_val("abort_avg", 32'(res_avg), 0);
        check_val("abort_sum", 32'(res_sum), 0);
        check_val("abort_sat", 32'(res_sat), 0);
        seen = 0;
        repeat (80) begin
            tick();
            if (res_valid || busy) seen++;
        end
        check_val("abort_no_result", seen, 0);
        meas(128, 8, 0, 0);

        // trig held high: a new measurement only after each handshake.
        for (int i = 0; i < NS; i++) tc_pat[i] = 32'h0000_0007;
        trig = 1'b1;
        tick();
        wait_result(r, ok);
        if (ok) begin
            accept(r, 3, 1'b1);
            tick();
            check_val("rearm_busy", 32'(busy), 1);
            wait_result(r, ok);
            if (ok) begin
                check_val("rearm_sum", 32'(res_sum), 48);
                accept(r, 0, 1'b0);
            end
        end
        trig = 1'b0;
        repeat (3) tick();
        check_val("final_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
